// File: rtl/usrt_pkg.sv
// Shared USRT definitions: receiver FSM states and parity mode codes,
// common to the receiver and the planned transmitter.
package usrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } usrt_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/usrt_rx_param_if.sv
// Host-side receive port of the USRT: word, valid/ready handshake, status flags.
interface usrt_rx_param_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  RX_VALID;
  logic                  RX_READY;
  logic                  NINTI;
  logic                  PAR_ERR;
  logic                  FRM_ERR;
  logic                  OVERRUN;

  modport master (
    output RX_DATA, RX_VALID, NINTI, PAR_ERR, FRM_ERR, OVERRUN,
    input  RX_READY
  );

  modport slave (
    input  RX_DATA, RX_VALID, NINTI, PAR_ERR, FRM_ERR, OVERRUN,
    output RX_READY
  );

endinterface

// File: rtl/usrt_rx_outbuf.sv
// Output holding register of the USRT receiver: captures a finished word on LOAD,
// runs the valid/ready handshake and flags words that replaced unconsumed ones.
module usrt_rx_outbuf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLOCK,
  input  logic                  NRESET,
  input  logic                  LOAD,
  input  logic [DATA_WIDTH-1:0] LOAD_DATA,
  input  logic                  LOAD_PERR,
  input  logic                  LOAD_FERR,
  usrt_rx_param_if.master       rx
);

  logic valid_q;

  // A LOAD coinciding with a handshake consumes the old word, so no overrun then.
  always_ff @(posedge CLOCK or negedge NRESET) begin
    if (!NRESET) begin
      valid_q    <= 1'b0;
      rx.RX_DATA <= '0;
      rx.PAR_ERR <= 1'b0;
      rx.FRM_ERR <= 1'b0;
      rx.OVERRUN <= 1'b0;
    end else if (LOAD) begin
      valid_q    <= 1'b1;
      rx.RX_DATA <= LOAD_DATA;
      rx.PAR_ERR <= LOAD_PERR;
      rx.FRM_ERR <= LOAD_FERR;
      rx.OVERRUN <= valid_q & ~rx.RX_READY;
    end else if (valid_q && rx.RX_READY) begin
      valid_q <= 1'b0;
    end
  end

  assign rx.RX_VALID = valid_q;
  assign rx.NINTI    = ~valid_q;

endmodule

// File: rtl/usrt_rx_param.sv
// Parametrised synchronous serial receiver: one SI sample per BIT_EN strobe,
// start/data/parity/stop framing, results handed to the output register.
module usrt_rx_param
  import usrt_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int MSB_FIRST   = 0
) (
  input  logic            CLOCK,
  input  logic            NRESET,
  input  logic            BIT_EN,
  input  logic            SI,
  output logic            BUSY,
  usrt_rx_param_if.master rx
);

  localparam int             CW        = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic           LAST_STOP = (STOP_BITS == 2);

  usrt_state_t           state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic                  stop_cnt;
  logic                  perr;
  logic                  ferr;
  logic                  load;

  function automatic logic par_err(input logic [DATA_WIDTH-1:0] d, input logic p);
    return (^{d, p}) ^ (PARITY_MODE == PAR_ODD);
  endfunction

  // LSB-first shifts right so the first bit ends in bit 0; MSB-first shifts left.
  assign shreg_nxt = (MSB_FIRST != 0) ? {shreg[DATA_WIDTH-2:0], SI}
                                      : {SI, shreg[DATA_WIDTH-1:1]};

  always_ff @(posedge CLOCK or negedge NRESET) begin
    if (!NRESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shreg    <= '0;
      stop_cnt <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else if (BIT_EN) begin
      case (state)
        ST_IDLE: begin
          if (!SI) begin
            state <= ST_DATA;
            cnt   <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
          end
        end
        ST_DATA: begin
          shreg <= shreg_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            state    <= (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            stop_cnt <= 1'b0;
          end
        end
        ST_PARITY: begin
          perr  <= par_err(shreg, SI);
          state <= ST_STOP;
        end
        ST_STOP: begin
          ferr <= ferr | ~SI;
          if (stop_cnt == LAST_STOP) state <= ST_IDLE;
          else                       stop_cnt <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The last stop sample is folded in combinationally so its frame error lands with the word.
  assign load = BIT_EN && (state == ST_STOP) && (stop_cnt == LAST_STOP);
  assign BUSY = (state != ST_IDLE);

  usrt_rx_outbuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outbuf (
    .CLOCK     (CLOCK),
    .NRESET    (NRESET),
    .LOAD      (load),
    .LOAD_DATA (shreg),
    .LOAD_PERR (perr),
    .LOAD_FERR (ferr | ~SI),
    .rx        (rx)
  );

endmodule

// File: tb/tb_usrt_rx_param.sv
// Bench for usrt_rx_param: several parameterisations share SI/BIT_EN and are
// checked one at a time against a frame-level reference model.
module tb_usrt_rx_param;

  logic clk = 1'b0;
  logic nreset, bit_en, si, rx_ready;
  logic busy0, busy1, busy2, busy3, busy5;
  int   n_checks = 0;
  int   n_fail   = 0;

  usrt_rx_param_if #(.DATA_WIDTH(8))  if0 ();
  usrt_rx_param_if #(.DATA_WIDTH(8))  if1 ();
  usrt_rx_param_if #(.DATA_WIDTH(8))  if2 ();
  usrt_rx_param_if #(.DATA_WIDTH(5))  if3 ();
  usrt_rx_param_if #(.DATA_WIDTH(12)) if5 ();

  assign if0.RX_READY = rx_ready;
  assign if1.RX_READY = rx_ready;
  assign if2.RX_READY = rx_ready;
  assign if3.RX_READY = rx_ready;
  assign if5.RX_READY = rx_ready;

  usrt_rx_param #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1), .MSB_FIRST(0)) d0 (
    .CLOCK(clk), .NRESET(nreset), .BIT_EN(bit_en), .SI(si), .BUSY(busy0), .rx(if0));
  usrt_rx_param #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1), .MSB_FIRST(0)) d1 (
    .CLOCK(clk), .NRESET(nreset), .BIT_EN(bit_en), .SI(si), .BUSY(busy1), .rx(if1));
  usrt_rx_param #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(2), .MSB_FIRST(0)) d2 (
    .CLOCK(clk), .NRESET(nreset), .BIT_EN(bit_en), .SI(si), .BUSY(busy2), .rx(if2));
  usrt_rx_param #(.DATA_WIDTH(5), .PARITY_MODE(2), .STOP_BITS(2), .MSB_FIRST(0)) d3 (
    .CLOCK(clk), .NRESET(nreset), .BIT_EN(bit_en), .SI(si), .BUSY(busy3), .rx(if3));
  usrt_rx_param #(.DATA_WIDTH(12), .PARITY_MODE(0), .STOP_BITS(1), .MSB_FIRST(1)) d5 (
    .CLOCK(clk), .NRESET(nreset), .BIT_EN(bit_en), .SI(si), .BUSY(busy5), .rx(if5));

  always #5 clk = ~clk;

  // Strobes that touch a busy period on d5: busy before or after the sampling edge.
  logic str_q, bprev_q;
  int   busy_strobes = 0;
  always @(posedge clk) begin
    str_q   <= bit_en;
    bprev_q <= busy5;
  end
  always @(negedge clk) if (str_q === 1'b1 && (bprev_q === 1'b1 || busy5 === 1'b1))
    busy_strobes <= busy_strobes + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] mask_w(input logic [15:0] w, input int dw);
    return w & 16'((32'd1 << dw) - 1);
  endfunction

  function automatic bit good_pbit(input logic [15:0] w, input int dw, input int pmode);
    int ones = $countones(mask_w(w, dw));
    return (pmode == 2) ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  function automatic bit exp_perr(input logic [15:0] w, input int dw, input int pmode, input bit pbit);
    if (pmode == 0) return 1'b0;
    return pbit != good_pbit(w, dw, pmode);
  endfunction

  function automatic bit exp_ferr(input logic [1:0] stops, input int nstop);
    for (int s = 0; s < nstop; s++) if (!stops[s]) return 1'b1;
    return 1'b0;
  endfunction

  // Drives one frame; returns on the negedge right after the last stop sample.
  task automatic send_frame(input logic [15:0] w, input int dw, input bit msb, input int pmode,
                            input bit pbit, input int nstop, input logic [1:0] stops,
                            input int period, input bit ready_last);
    bit q[$];
    q.push_back(1'b0);
    for (int i = 0; i < dw; i++) q.push_back(w[msb ? dw - 1 - i : i]);
    if (pmode != 0) q.push_back(pbit);
    for (int s = 0; s < nstop; s++) q.push_back(stops[s]);
    foreach (q[i]) begin
      si     = q[i];
      bit_en = 1'b1;
      if (ready_last && i == q.size() - 1) rx_ready = 1'b1;
      @(negedge clk);
      bit_en = 1'b0;
      if (i != q.size() - 1) repeat (period - 1) @(negedge clk);
    end
    si = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0; bit_en = 1'b0; si = 1'b1;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nreset = 1'b0; bit_en = 1'b0; si = 1'b1; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({if0.RX_DATA, if0.RX_VALID, if0.NINTI, if0.PAR_ERR, if0.FRM_ERR, if0.OVERRUN, busy0} !== 14'b00000000_0_1_0000) begin
      n_fail++; $display("FAIL reset_d0: got %b expected %b",
        {if0.RX_DATA, if0.RX_VALID, if0.NINTI, if0.PAR_ERR, if0.FRM_ERR, if0.OVERRUN, busy0}, 14'b00000000_0_1_0000);
    end
    n_checks++;
    if ({if5.RX_DATA, if5.RX_VALID, if5.NINTI, busy5} !== 15'b000000000000_0_1_0) begin
      n_fail++; $display("FAIL reset_d5: got %b expected %b", {if5.RX_DATA, if5.RX_VALID, if5.NINTI, busy5}, 15'b000000000000_0_1_0);
    end
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    rx_ready = 1'b1;
    send_frame(16'h00A5, 8, 0, 0, 0, 1, 2'b11, 1, 0);
    n_checks++;
    if (if0.RX_DATA !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h expected a5", if0.RX_DATA); end
    n_checks++;
    if ({if0.RX_VALID, if0.NINTI} !== 2'b10) begin n_fail++; $display("FAIL basic_valid: got %b expected 10", {if0.RX_VALID, if0.NINTI}); end
    n_checks++;
    if ({if0.PAR_ERR, if0.FRM_ERR, if0.OVERRUN} !== 3'b000) begin
      n_fail++; $display("FAIL basic_flags: got %b expected 000", {if0.PAR_ERR, if0.FRM_ERR, if0.OVERRUN});
    end
    @(negedge clk);
    n_checks++;
    if ({if0.RX_VALID, if0.NINTI, if0.RX_DATA} !== {2'b01, 8'hA5}) begin
      n_fail++; $display("FAIL basic_consume: got %b expected %b", {if0.RX_VALID, if0.NINTI, if0.RX_DATA}, {2'b01, 8'hA5});
    end
  endtask

  task automatic test_parity();
    do_reset();
    rx_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send_frame(16'h0007, 8, 0, 1, k[0], 1, 2'b11, 1, 0);
      n_checks++;
      if ({if1.RX_DATA, if1.PAR_ERR, if1.FRM_ERR} !== {8'h07, exp_perr(16'h0007, 8, 1, k[0]), 1'b0}) begin
        n_fail++; $display("FAIL parity_pbit%0d: got %b expected %b", k, {if1.RX_DATA, if1.PAR_ERR, if1.FRM_ERR},
          {8'h07, exp_perr(16'h0007, 8, 1, k[0]), 1'b0});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stop();
    logic [15:0] words [3] = '{16'h003C, 16'h0000, 16'h0096};
    logic [1:0]  stops [3] = '{2'b01, 2'b00, 2'b11};
    do_reset();
    rx_ready = 1'b1;
    // Frames follow each other with no idle gap, including right after the break.
    for (int k = 0; k < 3; k++) begin
      send_frame(words[k], 8, 0, 0, 0, 2, stops[k], 1, 0);
      n_checks++;
      if ({if2.RX_VALID, if2.RX_DATA, if2.FRM_ERR, if2.PAR_ERR} !== {1'b1, words[k][7:0], exp_ferr(stops[k], 2), 1'b0}) begin
        n_fail++; $display("FAIL stop_frame%0d: got %b expected %b", k, {if2.RX_VALID, if2.RX_DATA, if2.FRM_ERR, if2.PAR_ERR},
          {1'b1, words[k][7:0], exp_ferr(stops[k], 2), 1'b0});
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    rx_ready = 1'b0;
    send_frame(16'h0011, 8, 0, 0, 0, 1, 2'b11, 1, 0);
    n_checks++;
    if ({if0.RX_VALID, if0.RX_DATA, if0.OVERRUN} !== {1'b1, 8'h11, 1'b0}) begin
      n_fail++; $display("FAIL ovr_first: got %b expected %b", {if0.RX_VALID, if0.RX_DATA, if0.OVERRUN}, {1'b1, 8'h11, 1'b0});
    end
    @(negedge clk);
    send_frame(16'h0022, 8, 0, 0, 0, 1, 2'b11, 2, 0);
    n_checks++;
    if ({if0.RX_VALID, if0.RX_DATA, if0.OVERRUN} !== {1'b1, 8'h22, 1'b1}) begin
      n_fail++; $display("FAIL ovr_second: got %b expected %b", {if0.RX_VALID, if0.RX_DATA, if0.OVERRUN}, {1'b1, 8'h22, 1'b1});
    end
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({if0.RX_VALID, if0.RX_DATA, if0.OVERRUN} !== {1'b0, 8'h22, 1'b1}) begin
      n_fail++; $display("FAIL ovr_hold: got %b expected %b", {if0.RX_VALID, if0.RX_DATA, if0.OVERRUN}, {1'b0, 8'h22, 1'b1});
    end
    rx_ready = 1'b0;
    send_frame(16'h0011, 8, 0, 0, 0, 1, 2'b11, 1, 0);
    @(negedge clk);
    send_frame(16'h0022, 8, 0, 0, 0, 1, 2'b11, 1, 1);
    n_checks++;
    if ({if0.RX_VALID, if0.RX_DATA, if0.OVERRUN} !== {1'b1, 8'h22, 1'b0}) begin
      n_fail++; $display("FAIL ovr_same_edge: got %b expected %b", {if0.RX_VALID, if0.RX_DATA, if0.OVERRUN}, {1'b1, 8'h22, 1'b0});
    end
    @(negedge clk);
    n_checks++;
    if (if0.RX_VALID !== 1'b0) begin n_fail++; $display("FAIL ovr_same_edge_drain: got %b expected 0", if0.RX_VALID); end
  endtask

  task automatic test_strobe();
    int base;
    do_reset();
    rx_ready = 1'b1;
    base = busy_strobes;
    send_frame(16'h0ABC, 12, 1, 0, 0, 1, 2'b11, 4, 0);
    n_checks++;
    if ({if5.RX_VALID, if5.RX_DATA, if5.FRM_ERR} !== {1'b1, 12'hABC, 1'b0}) begin
      n_fail++; $display("FAIL strobe_data: got %b expected %b", {if5.RX_VALID, if5.RX_DATA, if5.FRM_ERR}, {1'b1, 12'hABC, 1'b0});
    end
    @(negedge clk);
    n_checks++;
    if (busy_strobes - base !== 1 + 12 + 0 + 1) begin
      n_fail++; $display("FAIL strobe_busy: got %0d strobes expected %0d", busy_strobes - base, 14);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    rx_ready = 1'b0;
    send_frame(16'h00C3, 8, 0, 0, 0, 1, 2'b11, 1, 0);
    si = 1'b0; bit_en = 1'b1;
    @(negedge clk);
    si = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy0, if0.RX_VALID} !== 2'b11) begin n_fail++; $display("FAIL mid_busy: got %b expected 11", {busy0, if0.RX_VALID}); end
    nreset = 1'b0; bit_en = 1'b0;
    #1;
    n_checks++;
    if ({if0.RX_DATA, if0.RX_VALID, if0.NINTI, if0.PAR_ERR, if0.FRM_ERR, if0.OVERRUN, busy0} !== 14'b00000000_0_1_0000) begin
      n_fail++; $display("FAIL mid_reset: got %b expected %b",
        {if0.RX_DATA, if0.RX_VALID, if0.NINTI, if0.PAR_ERR, if0.FRM_ERR, if0.OVERRUN, busy0}, 14'b00000000_0_1_0000);
    end
    @(negedge clk);
    nreset = 1'b1; rx_ready = 1'b1;
    @(negedge clk);
    send_frame(16'h005A, 8, 0, 0, 0, 1, 2'b11, 1, 0);
    n_checks++;
    if ({if0.RX_VALID, if0.RX_DATA, if0.FRM_ERR, if0.OVERRUN} !== {1'b1, 8'h5A, 2'b00}) begin
      n_fail++; $display("FAIL mid_next: got %b expected %b", {if0.RX_VALID, if0.RX_DATA, if0.FRM_ERR, if0.OVERRUN}, {1'b1, 8'h5A, 2'b00});
    end
  endtask

  task automatic test_random_even8();
    logic [15:0] w; logic [1:0] st; bit r, pbit, pending; int per;
    logic [11:0] exp;
    do_reset();
    pending = 1'b0;
    for (int n = 0; n < 24; n++) begin
      w    = 16'($urandom);
      r    = 1'($urandom_range(0, 1));
      pbit = good_pbit(w, 8, 1) ^ ($urandom_range(0, 3) == 0);
      st   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      per  = $urandom_range(1, 3);
      rx_ready = r;
      send_frame(w, 8, 0, 1, pbit, 1, st, per, 0);
      exp = {1'b1, w[7:0], exp_perr(w, 8, 1, pbit), exp_ferr(st, 1), pending & ~r};
      n_checks++;
      if ({if1.RX_VALID, if1.RX_DATA, if1.PAR_ERR, if1.FRM_ERR, if1.OVERRUN} !== exp) begin
        n_fail++; $display("FAIL rand_even8[%0d]: got %b expected %b", n,
          {if1.RX_VALID, if1.RX_DATA, if1.PAR_ERR, if1.FRM_ERR, if1.OVERRUN}, exp);
      end
      pending = ~r;
      @(negedge clk);
    end
  endtask

  task automatic test_random_odd5();
    logic [15:0] w; logic [1:0] st; bit r, pbit, pending; int per;
    logic [8:0] exp;
    do_reset();
    pending = 1'b0;
    for (int n = 0; n < 24; n++) begin
      w    = 16'($urandom);
      r    = 1'($urandom_range(0, 1));
      pbit = good_pbit(w, 5, 2) ^ ($urandom_range(0, 3) == 0);
      st   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      per  = $urandom_range(1, 3);
      rx_ready = r;
      send_frame(w, 5, 0, 2, pbit, 2, st, per, 0);
      exp = {1'b1, w[4:0], exp_perr(w, 5, 2, pbit), exp_ferr(st, 2), pending & ~r};
      n_checks++;
      if ({if3.RX_VALID, if3.RX_DATA, if3.PAR_ERR, if3.FRM_ERR, if3.OVERRUN} !== exp) begin
        n_fail++; $display("FAIL rand_odd5[%0d]: got %b expected %b", n,
          {if3.RX_VALID, if3.RX_DATA, if3.PAR_ERR, if3.FRM_ERR, if3.OVERRUN}, exp);
      end
      pending = ~r;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop();
    test_overrun();
    test_strobe();
    test_reset_midframe();
    test_random_even8();
    test_random_odd5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
